// File: rtl/blake2_msg_packer.sv
// Byte-stream to 1024-bit block packer in front of the BLAKE2b core.
// Holds each full block until more data is seen, so every message ends in exactly one final.
module blake2_msg_packer #(
   parameter int BLOCK_BYTES = 128
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               s_data,
   input  logic                     s_valid,
   input  logic                     s_last,
   output logic                     s_ready,
   input  logic                     core_ready,
   input  logic                     digest_valid,
   output logic                     init,
   output logic                     next,
   output logic                     final_blk,   // "final" is a reserved word
   output logic [8*BLOCK_BYTES-1:0] block,
   output logic [127:0]             length,
   output logic                     busy
);

   localparam int BLK_W = 8 * BLOCK_BYTES;

   typedef enum logic [2:0] {
      IDLE, INIT, FILL, FULL, SEND_NEXT, SEND_FINAL, WAIT_DIGEST
   } state_t;

   state_t     state, state_d;
   logic [6:0] idx;
   logic [9:0] bit_hi;
   logic       accept, cmd_q, fire;

   assign s_ready = (state == FILL);
   assign busy    = (state != IDLE);
   assign accept  = s_ready & s_valid;
   assign cmd_q   = init | next | final_blk;
   // Pulses are registered: the decision is taken one cycle ahead from the
   // state being entered, so the pulse is visible while that state is held.
   assign fire    = core_ready & ~cmd_q;
   assign bit_hi  = 10'(BLK_W - 1) - {idx, 3'b000};

   always_comb begin
      state_d = state;
      case (state)
         IDLE:        if (s_valid) state_d = INIT;
         INIT:        if (init) state_d = FILL;
         FILL: begin
            if (s_valid) begin
               if (s_last)                             state_d = SEND_FINAL;
               else if (idx == 7'(BLOCK_BYTES - 1))    state_d = FULL;
            end
         end
         FULL:        if (s_valid) state_d = SEND_NEXT;
         SEND_NEXT:   if (next) state_d = FILL;
         SEND_FINAL:  if (final_blk) state_d = WAIT_DIGEST;
         WAIT_DIGEST: if (digest_valid) state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         init      <= 1'b0;
         next      <= 1'b0;
         final_blk <= 1'b0;
         block     <= '0;
         length    <= '0;
         idx       <= '0;
      end else begin
         state     <= state_d;
         init      <= fire && (state_d == INIT);
         next      <= fire && (state_d == SEND_NEXT);
         final_blk <= fire && (state_d == SEND_FINAL);
         if (state == INIT && init) begin
            block  <= '0;
            length <= '0;
            idx    <= '0;
         end else if (state == SEND_NEXT && next) begin
            block  <= '0;
            idx    <= '0;
         end else if (accept) begin
            block[bit_hi -: 8] <= s_data;
            idx    <= idx + 7'd1;
            length <= length + 128'd1;
         end
      end
   end

endmodule

// File: doc/blake2_msg_packer.md
# blake2_msg_packer

Upstream stage of the BLAKE2 hashing core. It accepts a message as a byte stream over a valid/ready handshake and packs it into 1024-bit blocks. It drives the core's `init`/`next`/`final` command pulses, together with the block and the running byte `length`. It holds each full block until it knows whether that block is the last one, so the core always receives exactly one `final` per message.

## Interface
- `BLOCK_BYTES`, 128: bytes per block; fixed by BLAKE2b; the only supported value.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_data`  in  8  message byte.
- `s_valid`  in  1  `s_data` is valid; the source holds `s_data`/`s_last` stable until accepted.
- `s_last`  in  1  this byte is the last of the message.
- `s_ready`  out  1  the packer accepts the byte this cycle.
- `core_ready`  in  1  the core is idle and can take a command.
- `digest_valid`  in  1  the core has produced the digest for the current message.
- `init`  out  1  one-cycle pulse; starts a new hash.
- `next`  out  1  one-cycle pulse; `block` is a full, non-final block.
- `final`  out  1  one-cycle pulse; `block` is the last block, zero-padded.
- `block`  out  1024  block data; first byte of the block in [1023:1016], byte k in [1023-8k -: 8].
- `length`  out  128  total message bytes consumed so far; valid on `final`.
- `busy`  out  1  a message is in flight: from leaving IDLE until return to IDLE.

## Operation
- States: IDLE, INIT, FILL, FULL, SEND_NEXT, SEND_FINAL, WAIT_DIGEST.
- **Reset:** state=IDLE; `init`/`next`/`final`/`s_ready`/`busy`=0; `block`=0; `length`=0; byte index=0.
- **IDLE:** `s_ready`=0. When `s_valid`=1, go to INIT. The byte is not consumed.
- **INIT:** pulse `init` in the first cycle in which a command is allowed, then go to FILL. `block`, `length` and the byte index are cleared to 0 in the same cycle.
- **Command rule:** a command pulse (`init`/`next`/`final`) is issued only when `core_ready`=1 and no command pulse occurred in the previous cycle. At most one command is pulsed per cycle.
- **FILL:** `s_ready`=1. On accept:
  - The byte is written at the current index, the index is incremented and `length` is incremented by 1.
  - If `s_last`=1, go to SEND_FINAL.
  - Else if the byte was index 127, go to FULL.
- **FULL:** `s_ready`=0. This state waits until `s_valid`=1, peeking at the byte without consuming it, then goes to SEND_NEXT. The block is never sent as `next` before further data is known to exist.
- **SEND_NEXT:** pulse `next` with the held block when allowed. In the same cycle the block and index are cleared. Then go to FILL.
- **SEND_FINAL:** pulse `final` when allowed. Unwritten bytes of `block` are already 0, giving the zero padding. Then go to WAIT_DIGEST.
- **WAIT_DIGEST:** wait for `digest_valid`=1, then go to IDLE. `block` and `length` hold their values until the next INIT.
- **Widths:** `length` is a 128-bit counter that wraps modulo 2^128 and is not checked. The byte index is 7 bits.
- **Unsupported:** zero-length messages. A message always carries at least one byte with `s_last`=1.
- **Reset mid-message:** returns immediately to the reset values. No command pulse is generated, and any partial block is discarded.
- **Input ignored:** `s_valid`/`s_last` are ignored outside FILL, except for the FULL peek and the IDLE start detection.

## Timing
- Start of message, with `core_ready`=1 throughout:
  - cycle 0: IDLE sees `s_valid`.
  - cycle 1: `init` pulse.
  - cycle 2: first byte accepted.
- FILL accepts one byte per cycle when `s_valid`=1.
- Last byte accepted in cycle t: `final` in cycle t+1 at the earliest.
- 128th non-last byte accepted in cycle t, next byte valid at t+1:
  - t+1: FULL.
  - t+2: `next`.
  - t+3: byte accepted.
- `final` arriving right after `next`: delayed by at least one cycle by the command rule.
- `core_ready`=0: the pending pulse stalls. `block` and `length` stay stable while stalled.
- Command outputs: registered, exactly one cycle wide.
- `busy`: 1 from the first cycle in INIT through the cycle in which WAIT_DIGEST sees `digest_valid`.

## Test plan
- **"abc" (0x61,0x62,0x63, last on 0x63):** one `init` and one `final`, no `next`. `block[1023:1000]`=0x616263, remaining bits 0, `length`=3.
- **128 bytes 0x00..0x7F, last on 0x7F:** `init` then `final` only. `block[1023:1016]`=0x00, `block[7:0]`=0x7F, `length`=128. FULL is never entered, because `s_last` sends the block straight to SEND_FINAL.
- **129 bytes 0x00..0x80:**
  - `next` carries bytes 0x00..0x7F with `length`=128.
  - `final` carries `block[1023:1016]`=0x80, rest 0, with `length`=129.
  - `s_ready`=0 in the FULL cycle.
- **Core back-pressure:** `core_ready`=0 for 5 cycles around each command. Each pulse occurs only in the first allowed cycle, no pulses are dropped or duplicated, and `block` is stable during the stall.
- **Reset mid-message:** assert `rst` after 60 bytes. All outputs return to 0 and `busy`=0. A following "abc" message hashes exactly as in the first scenario.
- **Digest wait and back-to-back messages:**
  - Hold `digest_valid`=0 for 10 cycles after `final`: `s_ready` stays 0 and `busy` stays 1.
  - Raise `digest_valid`: the second message starts with a fresh `init` and `length` counts from 0.
